// File: rtl/bsg_gateway_wh_latency_channel.sv
// rtl/bsg_gateway_wh_latency_channel.sv - wormhole flit channel with modelled wire latency and credit flow control
module bsg_gateway_wh_latency_channel #(
    parameter int width_p     = 16,
    parameter int delay_p     = 4,
    parameter int els_p       = 2 * delay_p + 2,
    parameter int cnt_width_p = 32
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [width_p-1:0]     data_i,
    input  logic                   v_i,
    output logic                   ready_o,
    output logic [width_p-1:0]     data_o,
    output logic                   v_o,
    input  logic                   ready_i,
    output logic [cnt_width_p-1:0] flit_count_o
);

    localparam int credit_w_lp = $clog2(els_p + 1);
    localparam int ptr_w_lp    = (els_p > 1) ? $clog2(els_p) : 1;
    localparam logic [credit_w_lp-1:0] credit_max_lp = credit_w_lp'(els_p);
    localparam logic [credit_w_lp-1:0] credit_one_lp = credit_w_lp'(1);
    localparam logic [ptr_w_lp-1:0]    ptr_last_lp   = ptr_w_lp'(els_p - 1);
    localparam logic [ptr_w_lp-1:0]    ptr_one_lp    = ptr_w_lp'(1);
    localparam logic [cnt_width_p-1:0] cnt_one_lp    = cnt_width_p'(1);

    // Credits held upstream; equals free FIFO slots as seen a round trip late
    logic [credit_w_lp-1:0] credit_q, credit_d;
    // Forward wire pipe
    logic [delay_p-1:0]     fwd_v_q, fwd_v_d;
    logic [width_p-1:0]     fwd_data_q [delay_p];
    logic [width_p-1:0]     fwd_data_d [delay_p];
    // Credit-return wire pipe
    logic [delay_p-1:0]     ret_q, ret_d;
    // Receive FIFO
    logic [width_p-1:0]     mem_q [els_p];
    logic [width_p-1:0]     mem_d [els_p];
    logic [ptr_w_lp-1:0]    rd_ptr_q, rd_ptr_d;
    logic [ptr_w_lp-1:0]    wr_ptr_q, wr_ptr_d;
    logic [credit_w_lp-1:0] count_q, count_d;
    // Accepted-flit debug counter
    logic [cnt_width_p-1:0] flit_count_q, flit_count_d;

    logic accept;
    logic deq;
    logic enq;
    logic credit_ret;

    // Ready comes only from the credit register so upstream sees no combinational loop
    assign ready_o      = ~reset_i & (credit_q != '0);
    assign v_o          = ~reset_i & (count_q != '0);
    assign data_o       = mem_q[rd_ptr_q];
    assign flit_count_o = flit_count_q;
    assign accept       = v_i & ready_o;
    assign deq          = v_o & ready_i;
    assign enq          = fwd_v_q[delay_p-1];
    assign credit_ret   = ret_q[delay_p-1];

    // Next-state for pipes, FIFO pointers/occupancy, credits and flit counter
    always_comb begin
        fwd_v_d        = '0;
        ret_d          = '0;
        fwd_v_d[0]     = accept;
        fwd_data_d[0]  = data_i;
        ret_d[0]       = deq;
        for (int i = 1; i < delay_p; i++) begin
            fwd_v_d[i]    = fwd_v_q[i-1];
            fwd_data_d[i] = fwd_data_q[i-1];
            ret_d[i]      = ret_q[i-1];
        end

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (enq) begin
            mem_d[wr_ptr_q] = fwd_data_q[delay_p-1];
            wr_ptr_d = (wr_ptr_q == ptr_last_lp) ? '0 : wr_ptr_q + ptr_one_lp;
        end
        if (deq) begin
            rd_ptr_d = (rd_ptr_q == ptr_last_lp) ? '0 : rd_ptr_q + ptr_one_lp;
        end

        count_d = count_q;
        case ({enq, deq})
            2'b10:   count_d = count_q + credit_one_lp;
            2'b01:   count_d = count_q - credit_one_lp;
            default: count_d = count_q;
        endcase

        credit_d = credit_q;
        case ({accept, credit_ret})
            2'b10:   credit_d = credit_q - credit_one_lp;
            2'b01:   credit_d = credit_q + credit_one_lp;
            default: credit_d = credit_q;
        endcase

        flit_count_d = accept ? flit_count_q + cnt_one_lp : flit_count_q;
    end

    // Control state register; reset drops everything in flight and restores credits
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            credit_q     <= credit_max_lp;
            fwd_v_q      <= '0;
            ret_q        <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            flit_count_q <= '0;
        end else begin
            credit_q     <= credit_d;
            fwd_v_q      <= fwd_v_d;
            ret_q        <= ret_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            flit_count_q <= flit_count_d;
        end
    end

    // Flit payload storage; contents are qualified by the valid bits and need no reset
    always_ff @(posedge clk_i) begin
        fwd_data_q <= fwd_data_d;
        mem_q      <= mem_d;
    end

    // Credit conservation: overflow and excess credit mean the accounting is broken
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(enq && !deq && (count_q == credit_max_lp)));
            assert (credit_q <= credit_max_lp);
            assert (int'(credit_q) + $countones(fwd_v_q) + int'(count_q) + $countones(ret_q) == els_p);
        end
    end

endmodule

// File: tb/tb_bsg_gateway_wh_latency_channel.sv
// tb/tb_bsg_gateway_wh_latency_channel.sv - randomized self-checking bench for bsg_gateway_wh_latency_channel
module tb_bsg_gateway_wh_latency_channel;

    localparam int W  = 16;
    localparam int D  = 4;
    localparam int E  = 2 * D + 2;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  data_a, data_b;
    logic          v_a, v_b, rdy_a, rdy_b;
    logic          ready_oa, ready_ob, v_oa, v_ob;
    logic [W-1:0]  data_oa, data_ob;
    logic [CW-1:0] cnt_a, cnt_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bsg_gateway_wh_latency_channel #(.width_p(W), .delay_p(D), .els_p(E), .cnt_width_p(CW)) dut_a (
        .clk_i(clk), .reset_i(reset), .data_i(data_a), .v_i(v_a), .ready_o(ready_oa),
        .data_o(data_oa), .v_o(v_oa), .ready_i(rdy_a), .flit_count_o(cnt_a)
    );

    bsg_gateway_wh_latency_channel #(.width_p(W), .delay_p(D), .els_p(3), .cnt_width_p(CW)) dut_b (
        .clk_i(clk), .reset_i(reset), .data_i(data_b), .v_i(v_b), .ready_o(ready_ob),
        .data_o(data_ob), .v_o(v_ob), .ready_i(rdy_b), .flit_count_o(cnt_b)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model for dut_a: each flit becomes visible delay+1 cycles after accept,
    // each dequeue hands its credit back delay+1 cycles later.
    typedef struct packed {
        int           elig;
        logic [W-1:0] data;
    } flit_t;

    flit_t       fq[$];
    int          rq[$];
    int          credits = E;
    int unsigned mcount = 0;
    int          b_next = 0;

    always @(negedge clk) begin
        bit er, ev;
        if (reset) begin
            check_eq("rst_ready", ready_oa, 1'b0);
            check_eq("rst_v", v_oa, 1'b0);
            fq.delete();
            rq.delete();
            credits = E;
            mcount  = 0;
        end else begin
            while (rq.size() > 0 && rq[0] <= cyc) begin
                void'(rq.pop_front());
                credits++;
            end
            er = (credits > 0);
            ev = (fq.size() > 0) && (fq[0].elig <= cyc);
            check_eq("ready_o", ready_oa, er);
            check_eq("v_o", v_oa, ev);
            if (ev) check_eq("data_o", data_oa, fq[0].data);
            check_eq("flit_count", cnt_a, mcount);
            if (v_a && er) begin
                fq.push_back('{cyc + D + 1, data_a});
                credits--;
                mcount++;
            end
            if (ev && rdy_a) begin
                void'(fq.pop_front());
                rq.push_back(cyc + D + 1);
            end
        end
    end

    // dut_b delivers its flits in order with no loss
    always @(negedge clk) begin
        if (!reset && v_ob && rdy_b) begin
            check_eq("b_data", data_ob, b_next);
            b_next++;
        end
    end

    initial begin
        int t, nv, vc, drops, acc, k, d, rise, n0, rb, pr;
        v_a = 0; v_b = 0; rdy_a = 1; rdy_b = 1; data_a = '0; data_b = '0;
        repeat (3) tick();
        reset = 0;
        tick();

        // els_p=3: 3 accepts per 2*delay+2 cycles
        v_b = 1; data_b = '0; rb = cyc; acc = 0;
        repeat (60) begin
            @(negedge clk);
            check_eq("b_ready", ready_ob, ((cyc - rb) % 10) < 3);
            if (ready_ob) acc++;
            tick();
            data_b = W'(acc);
        end
        v_b = 0;
        repeat (20) tick();
        check_eq("b_accepts", acc, 18);
        check_eq("b_delivered", b_next, 18);

        // single flit latency
        repeat (3) tick();
        v_a = 1; data_a = 16'hA5; t = cyc;
        tick();
        v_a = 0; nv = 0; vc = -1;
        repeat (12) begin
            @(negedge clk);
            if (v_oa) begin nv++; vc = cyc; end
        end
        check_eq("single_cycle", vc, t + D + 1);
        check_eq("single_count", nv, 1);

        // 100 back-to-back flits
        n0 = mcount; drops = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            v_a = 1; data_a = W'(i);
            @(negedge clk);
            if (!ready_oa) drops++;
        end
        tick();
        v_a = 0;
        repeat (10) tick();
        check_eq("b2b_drops", drops, 0);
        check_eq("b2b_count", cnt_a, n0 + 100);

        // fill with downstream stalled
        rdy_a = 0; acc = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            v_a = 1; data_a = W'(acc);
            @(negedge clk);
            if (ready_oa) acc++;
        end
        tick();
        v_a = 0;
        check_eq("fill_accepts", acc, 10);
        check_eq("fill_ready_low", ready_oa, 1'b0);

        // release downstream: credit returns after the round trip
        repeat (3) tick();
        rdy_a = 1; d = cyc; rise = -1; k = 0;
        repeat (20) begin
            @(negedge clk);
            if (ready_oa && rise < 0) rise = cyc;
            if (v_oa) begin check_eq("drain_order", data_oa, k); k++; end
            tick();
        end
        check_eq("credit_return", rise, d + D + 1);
        check_eq("drain_count", k, 10);

        // random traffic with alternating backpressure
        for (int i = 0; i < 1500; i++) begin
            tick();
            pr = ((i / 250) % 2 == 1) ? 20 : 90;
            v_a    = ($urandom_range(0, 3) != 0);
            rdy_a  = ($urandom_range(0, 99) < pr);
            data_a = W'($urandom);
        end
        tick();
        v_a = 0; rdy_a = 1;
        repeat (30) tick();

        // reset with flits in flight and buffered
        rdy_a = 0;
        repeat (6) begin
            tick();
            v_a = 1; data_a = W'($urandom);
        end
        tick();
        v_a = 0;
        tick();
        reset = 1;
        tick();
        reset = 0;
        @(negedge clk);
        check_eq("post_rst_v", v_oa, 1'b0);
        check_eq("post_rst_ready", ready_oa, 1'b1);
        check_eq("post_rst_count", cnt_a, 0);
        tick();
        rdy_a = 1; v_a = 1; data_a = 16'h3C; t = cyc;
        tick();
        v_a = 0; nv = 0; vc = -1;
        repeat (12) begin
            @(negedge clk);
            if (v_oa) begin nv++; vc = cyc; check_eq("post_rst_data", data_oa, 16'h3C); end
        end
        check_eq("post_rst_cycle", vc, t + D + 1);
        check_eq("post_rst_single", nv, 1);

        // full credit pool after reset
        rdy_a = 0; acc = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            v_a = 1; data_a = W'(i);
            @(negedge clk);
            if (ready_oa) acc++;
        end
        tick();
        v_a = 0;
        check_eq("post_rst_credits", acc, 10);
        rdy_a = 1;
        repeat (20) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
